// File: rtl/header_pkg.sv
// Shared definitions for the UART receiver: FSM states, register map, bit indices.
package header_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    // Register byte offsets within the UART region
    localparam logic [31:0] OFS_RX_DATA   = 32'h10;
    localparam logic [31:0] OFS_RX_CTRL   = 32'h14;
    localparam logic [31:0] OFS_BAUD      = 32'h18;
    localparam logic [31:0] OFS_RX_STATUS = 32'h1C;

    // RX_CTRL bit indices
    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_TWO_STOP   = 1;
    localparam int CTRL_ODD_PARITY = 2;

    // RX_STATUS bit indices
    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_PARITY_ERR = 3;
    localparam int ST_FRAME_ERR  = 4;

endpackage

// File: rtl/rx_fifo.sv
// Byte-wide receive FIFO; pointers wrap naturally (DEPTH is a power of two),
// an explicit occupancy count separates full from empty.
module rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    // A push into a full FIFO is only legal when a pop frees a slot the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: synchronizer, frame FSM, CSRs and receive FIFO.
module uart_rx
    import header_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    input  logic        rx_in,
    output logic [31:0] rdata,
    output logic        rx_valid
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             sync1, sync2;
    logic [2:0]       ctrl;
    logic [DIV_W-1:0] baud;
    logic             overrun, parity_err, frame_err;

    rx_state_t        state;
    logic [DIV_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bad, stop_bad;
    logic             push_q, par_fail_q, frm_fail_q;
    logic [7:0]       push_byte;

    logic             fifo_full, fifo_empty, fifo_push, pop, ovr_set;
    logic [7:0]       fifo_head;
    logic [CW-1:0]    fifo_count;
    logic [4:0]       status;
    logic             unused;

    assign unused    = ^{wdata[31:DIV_W], fifo_count};
    assign rx_valid  = !fifo_empty;
    assign pop       = rd_en && !reset && (addr == OFS_RX_DATA) && !fifo_empty;
    assign fifo_push = push_q && (!fifo_full || pop);
    assign ovr_set   = push_q && fifo_full && !pop;
    assign status    = {frame_err, parity_err, overrun, fifo_full, !fifo_empty};

    rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .din   (push_byte),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Load data mux; zero unless a matching register is read outside reset
    always_comb begin
        rdata = '0;
        if (rd_en && !reset) begin
            case (addr)
                OFS_RX_DATA:   if (!fifo_empty) rdata[7:0] = fifo_head;
                OFS_RX_CTRL:   rdata[2:0] = ctrl;
                OFS_BAUD:      rdata[DIV_W-1:0] = baud;
                OFS_RX_STATUS: rdata[4:0] = status;
                default:       rdata = '0;
            endcase
        end
    end

    // Two-flop synchronizer, idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    // CSR writes and sticky flags; a same-cycle set beats a write-one-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl       <= '0;
            baud       <= '0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (wr_en && addr == OFS_RX_CTRL) ctrl <= wdata[2:0];
            if (wr_en && addr == OFS_BAUD)    baud <= wdata[DIV_W-1:0];
            overrun    <= ovr_set    || (overrun    && !(wr_en && addr == OFS_RX_STATUS && wdata[ST_OVERRUN]));
            parity_err <= par_fail_q || (parity_err && !(wr_en && addr == OFS_RX_STATUS && wdata[ST_PARITY_ERR]));
            frame_err  <= frm_fail_q || (frame_err  && !(wr_en && addr == OFS_RX_STATUS && wdata[ST_FRAME_ERR]));
        end
    end

    // Frame FSM: cnt counts down to the next mid-bit sample, reloaded from BAUD
    // at every sample so a new divisor takes effect on the following bit
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            push_q     <= 1'b0;
            push_byte  <= '0;
            par_fail_q <= 1'b0;
            frm_fail_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            par_fail_q <= 1'b0;
            frm_fail_q <= 1'b0;
            if (state != IDLE && !ctrl[CTRL_ENABLE]) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (ctrl[CTRL_ENABLE] && baud >= DIV_W'(2) && !sync2) begin
                    state <= START;
                    cnt   <= baud >> 1;
                end
            end else if (cnt > DIV_W'(1)) begin
                cnt <= cnt - DIV_W'(1);
            end else begin
                cnt <= baud;
                case (state)
                    START: begin
                        bit_idx <= '0;
                        state   <= sync2 ? IDLE : DATA;
                    end
                    DATA: begin
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bad <= (^{shreg, sync2}) ^ ctrl[CTRL_ODD_PARITY];
                        state   <= STOP1;
                    end
                    STOP1: begin
                        if (ctrl[CTRL_TWO_STOP]) begin
                            stop_bad <= !sync2;
                            state    <= STOP2;
                        end else begin
                            par_fail_q <= par_bad;
                            frm_fail_q <= !sync2;
                            push_q     <= !par_bad && sync2;
                            push_byte  <= shreg;
                            state      <= IDLE;
                        end
                    end
                    STOP2: begin
                        par_fail_q <= par_bad;
                        frm_fail_q <= stop_bad || !sync2;
                        push_q     <= !par_bad && !stop_bad && sync2;
                        push_byte  <= shreg;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus corner-case sequences,
// received bytes checked against a queue of expected bytes.
module tb_uart_rx;
    localparam int BAUD  = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        wr_en, rd_en;
    logic [31:0] wdata;
    logic        rx_in;
    logic [31:0] rdata;
    logic        rx_valid;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop1;
        logic       stop2;
        logic [2:0] ctrl;
        logic [4:0] status;
    } vec_t;
    vec_t vecs[6];

    uart_rx #(.FIFO_DEPTH(DEPTH), .DIV_W(14)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wdata    (wdata),
        .rx_in    (rx_in),
        .rdata    (rdata),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic csr_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic csr_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        #2 d = rdata;
        @(posedge clk); #1;
        rd_en = 1'b0; addr = '0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                              input logic s2, input logic two);
        logic [11:0] bits;
        int n;
        bits = {s2, s1, p, d, 1'b0};
        n = two ? 12 : 11;
        for (int i = 0; i < n; i++) begin
            rx_in = bits[i];
            repeat (BAUD) @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
    endtask

    task automatic expect_byte(input string name);
        logic [31:0] got;
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? {24'd0, sb_q.pop_front()} : 32'd0;
        csr_read(32'h10, got);
        check(name, got, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0] b;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 3'b001, 5'h01};  // even, good
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 3'b101, 5'h08};  // odd, bad parity
        vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b0, 3'b011, 5'h10};  // 2nd stop low
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b1, 3'b011, 5'h01};  // two stops, good
        vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 3'b101, 5'h01};  // odd, good
        vecs[5] = '{8'h07, 1'b0, 1'b0, 1'b1, 3'b001, 5'h18};  // parity + frame

        reset = 1'b1; rx_in = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        addr = 32'h1C; rd_en = 1'b1;
        #2 check("rdata_in_reset", rdata, 32'd0);
        rd_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        csr_read(32'h10, r); check("reset_rx_data", r, 32'd0);
        csr_read(32'h14, r); check("reset_ctrl", r, 32'd0);
        csr_read(32'h18, r); check("reset_baud", r, 32'd0);
        csr_read(32'h1C, r); check("reset_status", r, 32'd0);

        csr_write(32'h18, BAUD);
        csr_write(32'h14, 32'h1);
        csr_read(32'h18, r); check("cfg_baud", r, BAUD);
        csr_read(32'h14, r); check("cfg_ctrl", r, 32'h1);
        csr_read(32'h00, r); check("unmapped_read", r, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            logic good;
            good = (vecs[i].status[4:3] == 2'b00);
            csr_write(32'h14, {29'd0, vecs[i].ctrl});
            repeat (2) @(posedge clk);
            #1;
            if (good && sb_q.size() < DEPTH) sb_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop1, vecs[i].stop2,
                       vecs[i].ctrl[1]);
            check($sformatf("v%0d_rx_valid", i), {31'd0, rx_valid}, {31'd0, good});
            repeat (4) @(posedge clk);
            #1;
            csr_read(32'h1C, r);
            check($sformatf("v%0d_status", i), r, {27'd0, vecs[i].status});
            if (good) begin
                expect_byte($sformatf("v%0d_data", i));
                check($sformatf("v%0d_drained", i), {31'd0, rx_valid}, 32'd0);
            end else begin
                csr_write(32'h1C, {27'd0, vecs[i].status});
                csr_read(32'h1C, r);
                check($sformatf("v%0d_status_clr", i), r, 32'd0);
            end
        end

        // Overrun: five frames into a four-entry FIFO with no reads
        csr_write(32'h14, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            if (sb_q.size() < DEPTH) sb_q.push_back(b);
            send_frame(b, ^b, 1'b1, 1'b1, 1'b0);
            repeat (3) @(posedge clk);
            #1;
        end
        csr_read(32'h1C, r); check("ovr_status", r, 32'h07);
        for (int i = 0; i < 5; i++) expect_byte($sformatf("ovr_read%0d", i));
        check("ovr_empty", {31'd0, rx_valid}, 32'd0);

        // Reset in the middle of a frame, with a sticky flag and a queued byte
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        rx_in = 1'b0;                                    // start bit
        repeat (BAUD) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            repeat (BAUD) @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; rx_in = 1'b1;
        sb_q.delete();
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        csr_read(32'h1C, r); check("rst_mid_status", r, 32'd0);
        csr_write(32'h18, BAUD);
        csr_write(32'h14, 32'h1);
        sb_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_rst_valid", {31'd0, rx_valid}, 32'd1);
        expect_byte("post_rst_data");

        // Three-clock low glitch must not start a frame
        rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);
        csr_read(32'h1C, r); check("glitch_status", r, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
